// File: rtl/sync_pack_prefetch_fifo.sv
// sync_pack_prefetch_fifo: packs RATIO narrow input words into one wide word,
// stores wide words in a circular RAM and presents them first-word-fall-through
// through a prefetch register. Capacity is 2^DEPTH_WIDTH wide words, counting
// the prefetch register.
// Optional feature macro: SYNC_PACK_FIFO_FLUSH_EN adds flush / rd_partial so a
// partially packed word can be pushed out with its unfilled upper lanes zero.
module sync_pack_prefetch_fifo #(
  parameter int WR_DATA_WIDTH = 16,
  parameter int RATIO         = 16,
  parameter int DEPTH_WIDTH   = 8,
  parameter int AF_LEVEL      = 240,
  localparam int RD_DATA_WIDTH = WR_DATA_WIDTH * RATIO
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WR_DATA_WIDTH-1:0] wr_data,
  output logic                     wr_vld,
  input  logic                     rd_en,
  output logic                     rd_vld,
  output logic [RD_DATA_WIDTH-1:0] rd_data,
  output logic [DEPTH_WIDTH:0]     rd_fill,
  output logic                     almost_full
`ifdef SYNC_PACK_FIFO_FLUSH_EN
  ,
  input  logic                     flush,
  output logic                     rd_partial
`endif
);

  localparam int LW    = $clog2(RATIO);
  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [LW-1:0]          LANE_LAST = LW'(RATIO - 1);
  localparam logic [LW-1:0]          LANE_ONE  = LW'(1);
  localparam logic [DEPTH_WIDTH-1:0] PTR_ONE   = DEPTH_WIDTH'(1);
  localparam logic [DEPTH_WIDTH:0]   FILL_ONE  = (DEPTH_WIDTH + 1)'(1);
  localparam logic [DEPTH_WIDTH:0]   FILL_FULL = (DEPTH_WIDTH + 1)'(DEPTH);
  localparam logic [DEPTH_WIDTH:0]   AF_THR    = (DEPTH_WIDTH + 1)'(AF_LEVEL);

  logic [1:0]               rst_sync;
  logic                     rst_core_n;
  logic [LW-1:0]            lane;
  logic [RD_DATA_WIDTH-1:0] pack;
  logic [RD_DATA_WIDTH-1:0] pack_next;
  logic [DEPTH_WIDTH-1:0]   wr_ptr;
  logic [DEPTH_WIDTH-1:0]   rd_ptr;
  logic [RD_DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_WIDTH:0]     ram_cnt;
  logic                     wr_acc;
  logic                     pop;
  logic                     full_commit;
  logic                     flush_commit;
  logic                     commit;
  logic                     load;

  // Reset asserts at once but releases only after two clean clk edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_core_n = rst_sync[1];

  // Only a full block with the last lane occupied refuses input; registered state only.
  assign wr_vld      = !((rd_fill == FILL_FULL) && (lane == LANE_LAST));
  assign wr_acc      = wr_en && wr_vld;
  assign pop         = rd_en && rd_vld;
  assign full_commit = wr_acc && (lane == LANE_LAST);
  // Words still in RAM (the prefetch register holds the rest of rd_fill).
  assign ram_cnt     = rd_fill - {{DEPTH_WIDTH{1'b0}}, rd_vld};
  assign load        = (!rd_vld || pop) && (ram_cnt != '0);

`ifdef SYNC_PACK_FIFO_FLUSH_EN
  // A flush needs packed data (held or arriving now) and a free slot.
  assign flush_commit = flush && !full_commit && (wr_acc || (lane != '0)) &&
                        (rd_fill != FILL_FULL);
`else
  assign flush_commit = 1'b0;
`endif
  assign commit = full_commit || flush_commit;

  // Packer contents including the lane being written this cycle.
  always_comb begin
    pack_next = pack;
    for (int i = 0; i < RATIO; i++) begin
      if (wr_acc && (lane == LW'(i)))
        pack_next[i*WR_DATA_WIDTH +: WR_DATA_WIDTH] = wr_data;
    end
  end

  // Packer and write pointer; packer clears on commit so unfilled lanes read as zero.
  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      lane   <= '0;
      pack   <= '0;
      wr_ptr <= '0;
    end else if (commit) begin
      lane   <= '0;
      pack   <= '0;
      wr_ptr <= wr_ptr + PTR_ONE;
    end else if (wr_acc) begin
      lane   <= lane + LANE_ONE;
      pack   <= pack_next;
    end
  end

  // Storage RAM; contents survive reset since pointers alone define validity.
  always_ff @(posedge clk) begin
    if (commit) mem[wr_ptr] <= pack_next;
  end

  // Prefetch register, read pointer, fill count and almost-full flag.
  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      rd_vld      <= 1'b0;
      rd_data     <= '0;
      rd_ptr      <= '0;
      rd_fill     <= '0;
      almost_full <= 1'b0;
    end else begin
      if (load) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_ONE;
        rd_vld  <= 1'b1;
      end else if (pop) begin
        rd_vld  <= 1'b0;
      end
      case ({commit, pop})
        2'b10:   rd_fill <= rd_fill + FILL_ONE;
        2'b01:   rd_fill <= rd_fill - FILL_ONE;
        default: rd_fill <= rd_fill;
      endcase
      almost_full <= (rd_fill >= AF_THR);
    end
  end

`ifdef SYNC_PACK_FIFO_FLUSH_EN
  logic mem_part [DEPTH];

  // Marks each stored word as flushed-partial or complete.
  always_ff @(posedge clk) begin
    if (commit) mem_part[wr_ptr] <= flush_commit;
  end

  // Partial flag travels with the prefetched word.
  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n)  rd_partial <= 1'b0;
    else if (load)    rd_partial <= mem_part[rd_ptr];
  end
`endif

endmodule

// File: tb/tb_sync_pack_prefetch_fifo.sv
// Bench for sync_pack_prefetch_fifo: table-driven start-up vectors, hand-written
// corner sequences, and randomized traffic against a queue-based reference model.
// Define SYNC_PACK_FIFO_FLUSH_EN to exercise the flush feature.
module tb_sync_pack_prefetch_fifo;
  localparam int W     = 16;
  localparam int R     = 16;
  localparam int DW    = 8;
  localparam int AF    = 240;
  localparam int RDW   = W * R;
  localparam int DEPTH = 1 << DW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           wr_en = 1'b0;
  logic [W-1:0]   wr_data = '0;
  logic           rd_en = 1'b0;
  logic           wr_vld;
  logic           rd_vld;
  logic [RDW-1:0] rd_data;
  logic [DW:0]    rd_fill;
  logic           almost_full;
`ifdef SYNC_PACK_FIFO_FLUSH_EN
  logic           flush = 1'b0;
  logic           rd_partial;
`endif

  always #5 clk = ~clk;

  sync_pack_prefetch_fifo #(
    .WR_DATA_WIDTH(W), .RATIO(R), .DEPTH_WIDTH(DW), .AF_LEVEL(AF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_data(wr_data), .wr_vld(wr_vld),
    .rd_en(rd_en), .rd_vld(rd_vld), .rd_data(rd_data),
    .rd_fill(rd_fill), .almost_full(almost_full)
`ifdef SYNC_PACK_FIFO_FLUSH_EN
    , .flush(flush), .rd_partial(rd_partial)
`endif
  );

  // Reference model: a queue of complete words, each tagged with the edge that
  // committed it. A word is visible at the head one edge after its commit.
  typedef struct {
    logic [RDW-1:0] data;
    bit             part;
    int             tag;
  } word_t;

  word_t          q[$];
  int             m_lane = 0;
  int             m_t = 0;
  logic [RDW-1:0] m_pack = '0;
  bit             m_vld = 1'b0;
  bit             m_af = 1'b0;
  int             flush_ignored = 0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit           we;
    logic [W-1:0] wd;
    bit           re;
    bit           exp_vld;
    int           exp_fill;
    bit           exp_wvld;
  } vec_t;
  vec_t tbl[19];

  task automatic chk_w(string name, logic [RDW-1:0] act, logic [RDW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s t=%0d got %h want %h", name, m_t, act, exp);
    end
  endtask

  task automatic chk_i(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s t=%0d got %0d want %0d", name, m_t, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_lane = 0;
    m_pack = '0;
    m_vld  = 1'b0;
    m_af   = 1'b0;
  endtask

  task automatic push_word(bit part);
    word_t w;
    w.data = m_pack;
    w.part = part;
    w.tag  = m_t;
    q.push_back(w);
    m_pack = '0;
    m_lane = 0;
  endtask

  // One clock: drive inputs, predict, clock, compare every output to the model.
  task automatic step(bit we, logic [W-1:0] wd, bit re, bit fl);
    int size_before;
    bit acc;
    bit popm;
    bit full_c;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
`ifdef SYNC_PACK_FIFO_FLUSH_EN
    flush   = fl;
`endif
    size_before = q.size();
    acc  = we && !(size_before == DEPTH && m_lane == R - 1);
    popm = re && m_vld;
    @(posedge clk);
    #1;
    m_t++;
    if (popm) void'(q.pop_front());
    full_c = 1'b0;
    if (acc) begin
      m_pack[m_lane*W +: W] = wd;
      if (m_lane == R - 1) begin
        full_c = 1'b1;
        push_word(1'b0);
      end else begin
        m_lane++;
      end
    end
`ifdef SYNC_PACK_FIFO_FLUSH_EN
    if (fl && !full_c && m_lane != 0 && size_before < DEPTH) push_word(1'b1);
`else
    if (fl) flush_ignored++;
`endif
    m_af  = (size_before >= AF);
    m_vld = (q.size() > 0) && (q[0].tag <= m_t - 1);
    chk_i("rd_vld", int'(rd_vld), int'(m_vld));
    chk_i("rd_fill", int'(rd_fill), q.size());
    chk_i("wr_vld", int'(wr_vld), int'(!(q.size() == DEPTH && m_lane == R - 1)));
    chk_i("almost_full", int'(almost_full), int'(m_af));
    if (m_vld) begin
      chk_w("rd_data", rd_data, q[0].data);
`ifdef SYNC_PACK_FIFO_FLUSH_EN
      chk_i("rd_partial", int'(rd_partial), int'(q[0].part));
`endif
    end
  endtask

  // Asynchronous reset: outputs must clear before any clock edge arrives.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk_i("rst_rd_vld", int'(rd_vld), 0);
    chk_i("rst_rd_fill", int'(rd_fill), 0);
    chk_i("rst_af", int'(almost_full), 0);
    chk_i("rst_wr_vld", int'(wr_vld), 1);
    chk_w("rst_rd_data", rd_data, '0);
`ifdef SYNC_PACK_FIFO_FLUSH_EN
    chk_i("rst_partial", int'(rd_partial), 0);
    flush = 1'b0;
`endif
    wr_en = 1'b0;
    rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    model_reset();
  endtask

  initial begin
    logic [RDW-1:0] exp_word;

    for (int i = 0; i < 19; i++) begin
      tbl[i].we = (i < 16);
      tbl[i].wd = (i < 16) ? W'(i + 1) : '0;
      tbl[i].re = (i == 17);
      tbl[i].exp_vld  = (i == 16);
      tbl[i].exp_fill = (i == 15 || i == 16) ? 1 : 0;
      tbl[i].exp_wvld = 1'b1;
    end

    #1;
    do_reset();

    // Sixteen writes 0x0001..0x0010 make one word, visible one edge after commit.
    exp_word = '0;
    for (int i = 0; i < R; i++) exp_word[i*W +: W] = W'(i + 1);
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].we, tbl[i].wd, tbl[i].re, 1'b0);
      chk_i("tbl_vld", int'(rd_vld), int'(tbl[i].exp_vld));
      chk_i("tbl_fill", int'(rd_fill), tbl[i].exp_fill);
      chk_i("tbl_wvld", int'(wr_vld), int'(tbl[i].exp_wvld));
      if (i == 16) chk_w("tbl_word", rd_data, exp_word);
    end

    // Fill to capacity, then occupy the last lane so input stalls.
    for (int i = 0; i < DEPTH * R + R - 1; i++) step(1'b1, W'($urandom), 1'b0, 1'b0);
    chk_i("full_fill", int'(rd_fill), DEPTH);
    chk_i("full_af", int'(almost_full), 1);
    chk_i("full_wvld", int'(wr_vld), 0);
    for (int i = 0; i < 3; i++) step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    chk_i("drop_fill", int'(rd_fill), DEPTH);

    // One pop reopens input and the pending lane completes a word.
    step(1'b0, '0, 1'b1, 1'b0);
    chk_i("pop_fill", int'(rd_fill), DEPTH - 1);
    chk_i("pop_wvld", int'(wr_vld), 1);
    step(1'b1, 16'h5A5A, 1'b0, 1'b0);
    chk_i("refill", int'(rd_fill), DEPTH);
    for (int i = 0; i < DEPTH + 20; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk_i("drained", int'(rd_fill), 0);

    // Streaming: writes every cycle with reads always on.
    for (int i = 0; i < 10000; i++) begin
      step(1'b1, W'($urandom), 1'b1, 1'b0);
      chk_i("stream_fill_le1", int'(rd_fill <= 1), 1);
    end

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 6, W'($urandom), $urandom_range(0, 1) == 1,
           $urandom_range(0, 19) == 0);

    // Build fill 37 with lane count 5, then reset mid-operation.
    do_reset();
    for (int i = 0; i < 37 * R + 5; i++) step(1'b1, W'($urandom), 1'b0, 1'b0);
    chk_i("pre_rst_fill", int'(rd_fill), 37);
    do_reset();
    exp_word = '0;
    for (int i = 0; i < R; i++) begin
      exp_word[i*W +: W] = W'(16'h0100 + i);
      step(1'b1, W'(16'h0100 + i), 1'b0, 1'b0);
    end
    step(1'b0, '0, 1'b0, 1'b0);
    chk_i("post_rst_fill", int'(rd_fill), 1);
    chk_w("post_rst_word", rd_data, exp_word);
    step(1'b0, '0, 1'b1, 1'b0);

`ifdef SYNC_PACK_FIFO_FLUSH_EN
    // Flush with an empty packer does nothing.
    step(1'b0, '0, 1'b0, 1'b1);
    chk_i("noop_flush_fill", int'(rd_fill), 0);
    // Three lanes then flush gives a zero-padded partial word.
    step(1'b1, 16'hAAAA, 1'b0, 1'b0);
    step(1'b1, 16'hBBBB, 1'b0, 1'b0);
    step(1'b1, 16'hCCCC, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    exp_word = '0;
    exp_word[47:0] = 48'hCCCC_BBBB_AAAA;
    chk_w("flush_word", rd_data, exp_word);
    chk_i("flush_partial", int'(rd_partial), 1);
    chk_i("flush_fill", int'(rd_fill), 1);
    step(1'b0, '0, 1'b1, 1'b0);
    // Flush together with a write includes that write's lane.
    step(1'b1, 16'h1111, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    exp_word = '0;
    exp_word[15:0] = 16'h1111;
    chk_w("flush_wr_word", rd_data, exp_word);
    step(1'b0, '0, 1'b1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
